// File: rtl/bmf_shared_exp_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bmf_shared_exp_ctrl_if                                        |
// | Desc     : Element-in / shared-exponent-out / shift-out handshake bundle |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface bmf_shared_exp_ctrl_if #(
  parameter int NEXP   = 8,
  parameter int LENGTH = 16
);
  localparam int CW = $clog2(LENGTH + 1);

  logic            in_valid;
  logic            in_ready;
  logic [NEXP-1:0] in_exp;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [NEXP-1:0] out_max;
  logic [CW-1:0]   out_count;
  logic            sh_valid;
  logic            sh_ready;
  logic [NEXP-1:0] sh_amt;

  modport master (
    output in_valid, in_exp, in_last, out_ready, sh_ready,
    input  in_ready, out_valid, out_max, out_count, sh_valid, sh_amt
  );

  modport slave (
    input  in_valid, in_exp, in_last, out_ready, sh_ready,
    output in_ready, out_valid, out_max, out_count, sh_valid, sh_amt
  );
endinterface
`default_nettype wire

// File: rtl/bmf_shared_exp_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bmf_shared_exp_ctrl                                           |
// | Desc     : Groups element exponents into blocks and emits the block max; |
// |            BMF_EXP_BUFFER_EN adds per-element shift-amount drain.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bmf_shared_exp_ctrl #(
  parameter int NEXP   = 8,
  parameter int LENGTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  bmf_shared_exp_ctrl_if.slave  bus
);
  localparam int CW = $clog2(LENGTH + 1);
  localparam int IW = $clog2(LENGTH);

  localparam logic [1:0] ST_ACC   = 2'd0;
  localparam logic [1:0] ST_OUT   = 2'd1;
`ifdef BMF_EXP_BUFFER_EN
  localparam logic [1:0] ST_DRAIN = 2'd2;
`endif

  logic [1:0]      r_state;
  logic [CW-1:0]   r_count;
  logic [NEXP-1:0] r_max;
  logic [CW-1:0]   r_out_count;
  logic [NEXP-1:0] r_out_max;

  logic            w_accept;
  logic            w_close;
  logic [CW-1:0]   w_new_count;
  logic [NEXP-1:0] w_new_max;

  assign w_accept    = bus.in_valid && (r_state == ST_ACC);
  assign w_new_count = r_count + CW'(1);
  // First element of a block loads unconditionally so a cleared max never masks it.
  assign w_new_max   = ((r_count == '0) || (bus.in_exp > r_max)) ? bus.in_exp : r_max;
  assign w_close     = w_accept && (bus.in_last || (w_new_count == CW'(LENGTH)));

`ifdef BMF_EXP_BUFFER_EN
  logic [CW-1:0]   r_rd_idx;
  logic [NEXP-1:0] r_buf [LENGTH];

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_count[IW-1:0]] <= bus.in_exp;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ACC;
      r_count     <= '0;
      r_max       <= '0;
      r_out_count <= '0;
      r_out_max   <= '0;
`ifdef BMF_EXP_BUFFER_EN
      r_rd_idx    <= '0;
`endif
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_close) begin
            r_state     <= ST_OUT;
            r_out_max   <= w_new_max;
            r_out_count <= w_new_count;
            r_count     <= '0;
            r_max       <= '0;
          end else if (w_accept) begin
            r_count <= w_new_count;
            r_max   <= w_new_max;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
`ifdef BMF_EXP_BUFFER_EN
            r_state  <= ST_DRAIN;
            r_rd_idx <= '0;
`else
            r_state  <= ST_ACC;
`endif
          end
        end
`ifdef BMF_EXP_BUFFER_EN
        ST_DRAIN: begin
          if (bus.sh_ready) begin
            if (r_rd_idx == (r_out_count - CW'(1))) begin
              r_state  <= ST_ACC;
              r_rd_idx <= '0;
            end else begin
              r_rd_idx <= r_rd_idx + CW'(1);
            end
          end
        end
`endif
        default: r_state <= ST_ACC;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_ACC);
  assign bus.out_valid = (r_state == ST_OUT);
  assign bus.out_max   = r_out_max;
  assign bus.out_count = r_out_count;

`ifdef BMF_EXP_BUFFER_EN
  // Held block max is >= every stored element, so the difference never wraps.
  assign bus.sh_valid = (r_state == ST_DRAIN);
  assign bus.sh_amt   = (r_state == ST_DRAIN) ? (r_out_max - r_buf[r_rd_idx[IW-1:0]]) : '0;
`else
  logic w_unused_sh_ready;
  assign w_unused_sh_ready = bus.sh_ready;
  assign bus.sh_valid      = 1'b0;
  assign bus.sh_amt        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bmf_shared_exp_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bmf_shared_exp_ctrl                                        |
// | Desc     : Directed + random stimulus against a queue-based block model  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_bmf_shared_exp_ctrl;
  localparam int NEXP   = 8;
  localparam int LENGTH = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  bmf_shared_exp_ctrl_if #(.NEXP(NEXP), .LENGTH(LENGTH)) bus ();

  bmf_shared_exp_ctrl #(.NEXP(NEXP), .LENGTH(LENGTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: current partial block, pending outputs, pending shifts.
  int blk[$];
  int oq_max[$];
  int oq_cnt[$];
  int pend_sh[$];
  int shq[$];
  int stim[$];

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    blk.delete();
    oq_max.delete();
    oq_cnt.delete();
    pend_sh.delete();
    shq.delete();
  endtask

  task automatic model_close();
    int m;
    m = blk[0];
    foreach (blk[i]) if (blk[i] > m) m = blk[i];
    oq_max.push_back(m);
    oq_cnt.push_back(blk.size());
    pend_sh.delete();
    foreach (blk[i]) pend_sh.push_back(m - blk[i]);
    blk.delete();
  endtask

  // Called at posedge+1: drive inputs, check outputs, predict, advance one cycle.
  task automatic tick(input logic v, input logic [NEXP-1:0] e, input logic l,
                      input logic ordy, input logic shr, output bit acc);
    bit m_ir, m_ov, m_sv;
    bus.in_valid  = v;
    bus.in_exp    = e;
    bus.in_last   = l;
    bus.out_ready = ordy;
    bus.sh_ready  = shr;
    m_ir = (oq_max.size() == 0) && (shq.size() == 0);
    m_ov = (oq_max.size() != 0);
    m_sv = (shq.size() != 0);
    check_value("in_ready", 32'(bus.in_ready), 32'(m_ir));
    check_value("out_valid", 32'(bus.out_valid), 32'(m_ov));
    check_value("sh_valid", 32'(bus.sh_valid), 32'(m_sv));
    if (m_ov) begin
      check_value("out_max", 32'(bus.out_max), 32'(oq_max[0]));
      check_value("out_count", 32'(bus.out_count), 32'(oq_cnt[0]));
    end
    check_value("sh_amt", 32'(bus.sh_amt), m_sv ? 32'(shq[0]) : 32'd0);
    acc = v && m_ir;
    if (acc) begin
      blk.push_back(int'(e));
      if (l || blk.size() == LENGTH) model_close();
    end
    if (m_ov && ordy) begin
      void'(oq_max.pop_front());
      void'(oq_cnt.pop_front());
`ifdef BMF_EXP_BUFFER_EN
      shq = pend_sh;
`endif
      pend_sh.delete();
    end
    if (m_sv && shr) void'(shq.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic send_blk(input bit last_on_end, input logic ordy);
    bit acc;
    for (int i = 0; i < stim.size(); i++) begin
      int budget;
      acc = 1'b0;
      budget = 0;
      while (!acc && budget < 64) begin
        tick(1'b1, NEXP'(stim[i]), last_on_end && (i == stim.size() - 1), ordy, 1'b1, acc);
        budget++;
      end
      if (!acc) check_value("send_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    bit acc;
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, ordy, 1'b1, acc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check_value({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check_value({tag, "_out_max"}, 32'(bus.out_max), 32'd0);
    check_value({tag, "_out_count"}, 32'(bus.out_count), 32'd0);
    check_value({tag, "_sh_valid"}, 32'(bus.sh_valid), 32'd0);
    check_value({tag, "_sh_amt"}, 32'(bus.sh_amt), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    bit hold;
    logic v, l, ordy, shr;
    logic [NEXP-1:0] e;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_exp = '0; bus.in_last = 1'b0;
    bus.out_ready = 1'b0; bus.sh_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full block 0..15 back to back.
    stim.delete();
    for (int i = 0; i < LENGTH; i++) stim.push_back(i);
    send_blk(1'b0, 1'b1);
    idle(3, 1'b1);

    // Early close with backpressure until handshake.
    stim = '{3, 9, 4};
    send_blk(1'b1, 1'b0);
    idle(3, 1'b0);
    idle(2, 1'b1);

    // Backpressure with an extra element pending at the input.
    stim = '{50, 20};
    send_blk(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 8'd99, 1'b0, 1'b0, 1'b1, acc);
    stim = '{99};
    send_blk(1'b0, 1'b1);
    stim = '{5};
    send_blk(1'b1, 1'b1);
    idle(3, 1'b1);

    // Ties and zeros.
    stim = '{0, 0, 0, 0};
    send_blk(1'b1, 1'b1);
    idle(2, 1'b1);
    stim = '{200, 200, 7};
    send_blk(1'b1, 1'b1);
    idle(2, 1'b1);

    // in_last on the LENGTH-th element.
    stim.delete();
    for (int i = 0; i < LENGTH; i++) stim.push_back((i * 37 + 11) % 256);
    send_blk(1'b1, 1'b1);
    idle(3, 1'b1);

    // Reset mid-block discards the partial block.
    stim = '{30, 60, 90, 120, 150};
    send_blk(1'b0, 1'b1);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #2;
    check_reset_outputs("midreset");
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1, 1'b1);
    stim = '{1, 2};
    send_blk(1'b1, 1'b1);
    idle(3, 1'b1);

`ifdef BMF_EXP_BUFFER_EN
    // Drain with sh_ready toggling.
    stim = '{10, 13, 12};
    send_blk(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0, '0, 1'b0, 1'b1, 1'(i % 2), acc);
    idle(2, 1'b1);
`endif

    // Random traffic; the source holds its element until accepted.
    hold = 1'b0;
    v = 1'b0; e = '0; l = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!hold) begin
        v = ($urandom_range(0, 3) != 0);
        e = ($urandom_range(0, 1) != 0) ? NEXP'($urandom_range(0, 255)) : NEXP'($urandom_range(0, 3));
        l = ($urandom_range(0, 9) == 0);
      end
      ordy = ($urandom_range(0, 2) != 0);
      shr  = ($urandom_range(0, 1) != 0);
      tick(v, e, l, ordy, shr, acc);
      hold = v && !acc;
    end
    idle(40, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
